uart_rx_buffered: RTL and testbench

Buffered UART receiver: recovers 8N1 frames from the serial line into a small show-ahead FIFO. Consumer logic drains bytes with a one-cycle read strobe. It is the receive-side counterpart of the board's transmit path, taking PC-to-board traffic at the same bit timing. It flags framing errors and overruns, so a slow consumer loses bytes visibly rather than silently.

---
 rtl/uart_rx_buffered_if.sv | 25 ++
 rtl/uart_rx_buffered.sv | 150 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffered_if.sv
// Bundles the serial input, consumer read port and status flags of the buffered UART receiver.
// The receiver uses the slave side; the consumer/driver uses the master side.
interface uart_rx_buffered_if #(
  parameter int FIFO_AW = 2
);
  logic               rx;
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               empty;
  logic               full;
  logic [FIFO_AW:0]   count;
  logic               busy;
  logic               frame_err;
  logic               overrun;

  modport master (
    output rx, rd_en,
    input  rd_data, empty, full, count, busy, frame_err, overrun
  );

  modport slave (
    input  rx, rd_en,
    output rd_data, empty, full, count, busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a show-ahead circular FIFO.
// It reports framing errors and overruns as single-cycle pulses.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_buffered_if.slave bus
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CW-1:0]    BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic                rxMeta_q, rxs_q;
  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       bitCnt_q, bitCnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                frameErr_q, frameErr_d;
  logic                overrun_q, overrun_d;
  logic [FIFO_AW-1:0]  wrPtr_q, wrPtr_d;
  logic [FIFO_AW-1:0]  rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [7:0]          mem [DEPTH];
  logic                pushReq, push, pop, full, empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= bus.rx;
      rxs_q    <= rxMeta_q;
    end
  end

  // The bit counter restarts on every state change and after each data-bit sample.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q + 1'b1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    pushReq    = 1'b0;
    frameErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        bitCnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (bitCnt_q == BIT_HALF) begin
          bitCnt_d = '0;
          idx_d    = '0;
          state_d  = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          shift_d  = {rxs_q, shift_q[7:1]};
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          if (rxs_q) begin
            pushReq = 1'b1;
            state_d = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        bitCnt_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: begin
        bitCnt_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a push.
  always_comb begin
    push      = pushReq && !full;
    pop       = bus.rd_en && !empty;
    overrun_d = pushReq && full;
    wrPtr_d   = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d   = pop ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= shift_q;
  end

  assign bus.rd_data   = mem[rdPtr_q];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = frameErr_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered at 16 clocks per bit with a 4-entry FIFO.
// Bytes are queued as they are sent and compared as they are popped from the FIFO.
module tb_uart_rx_buffered;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic clk;
  logic rst_n;

  uart_rx_buffered_if #(.FIFO_AW(AW)) bus ();

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          passCount = 0;
  int          checkCount = 0;
  int          frameErrSeen = 0;
  int          overrunSeen = 0;
  logic [7:0]  expQ [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) frameErrSeen++;
    if (bus.overrun === 1'b1) overrunSeen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic popByte(output logic [7:0] got);
    got = bus.rd_data;
    bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic nextExpected(output logic [7:0] e, output logic ok);
    ok = (expQ.size() > 0);
    e  = 8'h00;
    if (ok) e = expQ.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    idle(4);
    checkCount++; if (bus.empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); else passCount++;
    checkCount++; if (bus.full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", bus.full); else passCount++;
    checkCount++; if (bus.count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); else passCount++;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passCount++;
    checkCount++; if (bus.frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err); else passCount++;
    checkCount++; if (bus.overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); else passCount++;
    rst_n = 1'b1;
    idle(3);
    checkCount++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) $display("[TB] FAIL after_reset_idle: got empty=%b busy=%b expected 1/0", bus.empty, bus.busy); else passCount++;
  endtask

  task automatic test_single_byte();
    int lat;
    logic [7:0] got, e;
    logic ok;
    lat = -1;
    expQ.push_back(8'hA5);
    fork
      sendFrame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(posedge clk);
          #1;
          if (bus.empty === 1'b0 && lat < 0) lat = i;
        end
      end
    join
    checkCount++; if (lat < 153 || lat > 157) $display("[TB] FAIL single_latency: got %0d cycles expected 155 +/-2", lat); else passCount++;
    checkCount++; if (bus.count !== 3'd1) $display("[TB] FAIL single_count: got %0d expected 1", bus.count); else passCount++;
    popByte(got);
    nextExpected(e, ok);
    checkCount++; if (!ok || got !== e) $display("[TB] FAIL single_data: got %h expected %h", got, e); else passCount++;
    checkCount++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) $display("[TB] FAIL single_drain: got empty=%b count=%0d expected 1/0", bus.empty, bus.count); else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic [7:0] got, e;
    logic ok;
    int ovBefore;
    bytes = '{8'h01, 8'h80, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(bytes[i]);
      sendFrame(bytes[i], 1'b1);
    end
    checkCount++; if (bus.full !== 1'b1 || bus.count !== 3'd4) $display("[TB] FAIL b2b_full: got full=%b count=%0d expected 1/4", bus.full, bus.count); else passCount++;
    ovBefore = overrunSeen;
    sendFrame(8'h3C, 1'b1);
    idle(2);
    checkCount++; if (overrunSeen - ovBefore != 1) $display("[TB] FAIL b2b_overrun_pulses: got %0d expected 1", overrunSeen - ovBefore); else passCount++;
    checkCount++; if (bus.count !== 3'd4) $display("[TB] FAIL b2b_count_after_overrun: got %0d expected 4", bus.count); else passCount++;
    for (int i = 0; i < 4; i++) begin
      popByte(got);
      nextExpected(e, ok);
      checkCount++; if (!ok || got !== e) $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, got, e); else passCount++;
    end
    checkCount++; if (bus.empty !== 1'b1) $display("[TB] FAIL b2b_empty: got %b expected 1", bus.empty); else passCount++;
  endtask

  task automatic test_frame_error();
    logic [7:0] got, e;
    logic ok;
    int feBefore;
    feBefore = frameErrSeen;
    sendFrame(8'h55, 1'b0);
    bus.rx = 1'b0;
    idle(3 * CPB);
    bus.rx = 1'b1;
    idle(2 * CPB);
    checkCount++; if (frameErrSeen - feBefore != 1) $display("[TB] FAIL ferr_pulses: got %0d expected 1", frameErrSeen - feBefore); else passCount++;
    checkCount++; if (bus.count !== 3'd0) $display("[TB] FAIL ferr_count: got %0d expected 0", bus.count); else passCount++;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL ferr_busy: got %b expected 0", bus.busy); else passCount++;
    expQ.push_back(8'h66);
    sendFrame(8'h66, 1'b1);
    idle(4);
    checkCount++; if (bus.count !== 3'd1) $display("[TB] FAIL ferr_recover_count: got %0d expected 1", bus.count); else passCount++;
    popByte(got);
    nextExpected(e, ok);
    checkCount++; if (!ok || got !== e) $display("[TB] FAIL ferr_recover_data: got %h expected %h", got, e); else passCount++;
  endtask

  task automatic test_glitch();
    int feBefore, ovBefore;
    logic sawBusy;
    feBefore = frameErrSeen;
    ovBefore = overrunSeen;
    sawBusy = 1'b0;
    bus.rx = 1'b0;
    for (int i = 1; i <= CPB / 2 + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == CPB / 4) bus.rx = 1'b1;
      if (bus.busy === 1'b1) sawBusy = 1'b1;
    end
    checkCount++; if (sawBusy !== 1'b1) $display("[TB] FAIL glitch_busy_seen: got %b expected 1", sawBusy); else passCount++;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL glitch_busy_drop: got %b expected 0", bus.busy); else passCount++;
    idle(2 * CPB);
    checkCount++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) $display("[TB] FAIL glitch_no_push: got count=%0d empty=%b expected 0/1", bus.count, bus.empty); else passCount++;
    checkCount++; if (frameErrSeen != feBefore || overrunSeen != ovBefore) $display("[TB] FAIL glitch_flags: got fe=%0d ov=%0d expected 0/0", frameErrSeen - feBefore, overrunSeen - ovBefore); else passCount++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, e, head;
    logic ok, ovAtEdge;
    int ovBefore;
    // Push and pop collide at 0 < count < depth.
    expQ.push_back(8'h11); sendFrame(8'h11, 1'b1);
    expQ.push_back(8'h22); sendFrame(8'h22, 1'b1);
    checkCount++; if (bus.count !== 3'd2) $display("[TB] FAIL simul_pre_count: got %0d expected 2", bus.count); else passCount++;
    expQ.push_back(8'h33);
    fork
      sendFrame(8'h33, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        head = bus.rd_data;
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
      end
    join
    checkCount++; if (bus.count !== 3'd2) $display("[TB] FAIL simul_count: got %0d expected 2", bus.count); else passCount++;
    nextExpected(e, ok);
    checkCount++; if (!ok || head !== e) $display("[TB] FAIL simul_head: got %h expected %h", head, e); else passCount++;
    for (int i = 0; i < 2; i++) begin
      popByte(got);
      nextExpected(e, ok);
      checkCount++; if (!ok || got !== e) $display("[TB] FAIL simul_order%0d: got %h expected %h", i, got, e); else passCount++;
    end
    // Same collision while full: the incoming byte is lost.
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(8'h44 + 8'(i * 17));
      sendFrame(8'h44 + 8'(i * 17), 1'b1);
    end
    checkCount++; if (bus.full !== 1'b1) $display("[TB] FAIL simul_full: got %b expected 1", bus.full); else passCount++;
    ovBefore = overrunSeen;
    ovAtEdge = 1'b0;
    fork
      sendFrame(8'h99, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        head = bus.rd_data;
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        ovAtEdge = bus.overrun;
      end
    join
    checkCount++; if (ovAtEdge !== 1'b1) $display("[TB] FAIL simul_overrun_edge: got %b expected 1", ovAtEdge); else passCount++;
    checkCount++; if (overrunSeen - ovBefore != 1) $display("[TB] FAIL simul_overrun_pulses: got %0d expected 1", overrunSeen - ovBefore); else passCount++;
    checkCount++; if (bus.count !== 3'd3) $display("[TB] FAIL simul_full_count: got %0d expected 3", bus.count); else passCount++;
    nextExpected(e, ok);
    checkCount++; if (!ok || head !== e) $display("[TB] FAIL simul_full_head: got %h expected %h", head, e); else passCount++;
    for (int i = 0; i < 3; i++) begin
      popByte(got);
      nextExpected(e, ok);
      checkCount++; if (!ok || got !== e) $display("[TB] FAIL simul_full_order%0d: got %h expected %h", i, got, e); else passCount++;
    end
    checkCount++; if (bus.empty !== 1'b1) $display("[TB] FAIL simul_empty: got %b expected 1", bus.empty); else passCount++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial, got, e;
    logic ok;
    int feBefore, ovBefore;
    expQ.push_back(8'hAA); sendFrame(8'hAA, 1'b1);
    expQ.push_back(8'hBB); sendFrame(8'hBB, 1'b1);
    checkCount++; if (bus.count !== 3'd2) $display("[TB] FAIL rstmid_pre_count: got %0d expected 2", bus.count); else passCount++;
    feBefore = frameErrSeen;
    ovBefore = overrunSeen;
    partial = 8'h99;
    bus.rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx = partial[i];
      idle(CPB);
    end
    bus.rx = partial[4];
    idle(CPB / 2);
    checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL rstmid_busy_before: got %b expected 1", bus.busy); else passCount++;
    rst_n = 1'b0;
    #1;
    checkCount++; if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.full !== 1'b0) $display("[TB] FAIL rstmid_fifo: got empty=%b count=%0d full=%b expected 1/0/0", bus.empty, bus.count, bus.full); else passCount++;
    checkCount++; if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) $display("[TB] FAIL rstmid_status: got busy=%b fe=%b ov=%b expected 0/0/0", bus.busy, bus.frame_err, bus.overrun); else passCount++;
    expQ.delete();
    bus.rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2 * CPB);
    expQ.push_back(8'hC3);
    sendFrame(8'hC3, 1'b1);
    idle(4);
    checkCount++; if (bus.count !== 3'd1) $display("[TB] FAIL rstmid_after_count: got %0d expected 1", bus.count); else passCount++;
    popByte(got);
    nextExpected(e, ok);
    checkCount++; if (!ok || got !== e) $display("[TB] FAIL rstmid_after_data: got %h expected %h", got, e); else passCount++;
    checkCount++; if (bus.empty !== 1'b1) $display("[TB] FAIL rstmid_only_byte: got empty=%b expected 1", bus.empty); else passCount++;
    checkCount++; if (frameErrSeen != feBefore || overrunSeen != ovBefore) $display("[TB] FAIL rstmid_flags: got fe=%0d ov=%0d expected 0/0", frameErrSeen - feBefore, overrunSeen - ovBefore); else passCount++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_simultaneous();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
